// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port MIPS register file.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned ZERO_IDX   = 0;

  // LSB of lane `port` in a flat bus of `width`-bit lanes.
  function automatic int unsigned lane_lsb(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: zero/wr1/wr0/storage priority mux feeding an enabled output register.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_index,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wr0_en,
  input  logic [ADDR_W-1:0] wr0_index,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr1_index,
  input  logic [DATA_W-1:0] wr1_data,
  output logic [DATA_W-1:0] rd_out
);

  logic [DATA_W-1:0] eff_data;
  logic [DATA_W-1:0] rd_d;
  logic [DATA_W-1:0] rd_q;

  // NOTE: combinational logic uses blocking '=' with a default assigned first,
  // so no latch is inferred; state registers use non-blocking '<=' only.
  always_comb begin
    eff_data = mem_data;
    if ((ZERO_REG != 0) && (rd_index == ADDR_W'(ZERO_IDX))) begin
      eff_data = '0;
    end else if (wr1_en && (wr1_index == rd_index)) begin
      eff_data = wr1_data;
    end else if (wr0_en && (wr0_index == rd_index)) begin
      eff_data = wr0_data;
    end
    rd_d = rd_en ? eff_data : rd_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign rd_out = rd_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: NUM_RD registered read ports, two prioritised write ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_index,
  output logic [NUM_RD*DATA_W-1:0] rd_out,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_index,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_index,
  input  logic [DATA_W-1:0]        wr1_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr0_ok;
  logic              wr1_ok;

  assign wr0_ok = wr0_en && !((ZERO_REG != 0) && (wr0_index == ADDR_W'(ZERO_IDX)));
  assign wr1_ok = wr1_en && !((ZERO_REG != 0) && (wr1_index == ADDR_W'(ZERO_IDX)));

  // NOTE: the whole array is reset because every register must read 0 after
  // reset; wr1 is assigned last so it wins a same-index conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wr0_ok) mem_q[wr0_index] <= wr0_data;
      if (wr1_ok) mem_q[wr1_index] <= wr1_data;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] idx;
    assign idx = rd_index[lane_lsb(p, ADDR_W) +: ADDR_W];

    regfile_rd_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG)
    ) u_rd_port (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_en    (rd_en[p]),
      .rd_index (idx),
      .mem_data (mem_q[idx]),
      .wr0_en   (wr0_en),
      .wr0_index(wr0_index),
      .wr0_data (wr0_data),
      .wr1_en   (wr1_en),
      .wr1_index(wr1_index),
      .wr1_data (wr1_data),
      .rd_out   (rd_out[lane_lsb(p, DATA_W) +: DATA_W])
    );
  end

endmodule
